// File: rtl/fifo_stream_reader.sv
// Purpose: read-side master for the dual-clock FIFO that turns pops into a framed valid/ready stream.
// Latency: pop issued in cycle N, word presented with m_valid in cycle N+2, one word per cycle sustained.
// Backpressure: m_ready low parks words in a 2-entry buffer and pops stop once buffer plus in-flight reach 2.
module fifo_stream_reader #(
  parameter int DWIDTH  = 16,
  parameter int PKT_LEN = 4,
  parameter int CNTW    = 8
) (
  input  logic              rd_clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  output logic [CNTW-1:0]   pkt_cnt,
  output logic              busy
);

  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

  logic [DWIDTH-1:0] head_q;
  logic [DWIDTH-1:0] tail_q;
  logic [1:0]        occ;
  logic              inflight;
  logic [7:0]        word_idx;
  logic              pop;
  logic [2:0]        pending_cnt;

  assign m_valid = (occ != 2'd0);
  assign m_data  = head_q;
  assign m_last  = m_valid && (word_idx == LAST_IDX);
  assign busy    = inflight || m_valid;
  assign pop     = m_valid && m_ready;

  // Words that will still occupy the buffer next cycle; a new pop is only
  // allowed if its returning word is guaranteed a free slot.
  assign pending_cnt = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en  = rstn && enable && !fifo_empty && (pending_cnt < 3'd2);

  // Track the FIFO's one-cycle read latency: a pop now means data arrives next cycle.
  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  // Two-entry buffer: shift on pop, returning word lands right after the surviving entries.
  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn) begin
      head_q <= '0;
      tail_q <= '0;
      occ    <= 2'd0;
    end else begin
      case ({inflight, pop})
        2'b01: begin
          head_q <= tail_q;
          occ    <= occ - 2'd1;
        end
        2'b10: begin
          if (occ == 2'd0) begin
            head_q <= fifo_data;
          end else begin
            tail_q <= fifo_data;
          end
          occ <= occ + 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head_q <= fifo_data;
          end else begin
            head_q <= tail_q;
            tail_q <= fifo_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Packet framing: advance the word index on every accepted word, count completed packets.
  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn) begin
      word_idx <= 8'd0;
      pkt_cnt  <= '0;
    end else if (pop) begin
      if (m_last) begin
        word_idx <= 8'd0;
        pkt_cnt  <= pkt_cnt + CNTW'(1);
      end else begin
        word_idx <= word_idx + 8'd1;
      end
    end
  end

  // A returning word must never find the buffer full with nothing leaving.
  a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rstn)
    (occ != 2'd3) && !(inflight && (occ == 2'd2) && !pop));

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;
  localparam int DWIDTH  = 16;
  localparam int PKT_LEN = 4;
  localparam int CNTW    = 8;

  logic              rd_clk;
  logic              rstn;
  logic              enable;
  logic              fifo_empty;
  logic [DWIDTH-1:0] fifo_data;
  logic              fifo_rd_en;
  logic              m_valid;
  logic              m_ready;
  logic [DWIDTH-1:0] m_data;
  logic              m_last;
  logic [CNTW-1:0]   pkt_cnt;
  logic              busy;

  fifo_stream_reader #(.DWIDTH(DWIDTH), .PKT_LEN(PKT_LEN), .CNTW(CNTW)) dut (
    .rd_clk(rd_clk), .rstn(rstn), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .pkt_cnt(pkt_cnt),
    .busy(busy)
  );

  initial begin
    rd_clk = 1'b0;
    forever #5 rd_clk = ~rd_clk;
  end

  typedef struct {
    logic [DWIDTH-1:0] w;
    int                t;
  } pend_t;

  typedef struct {
    logic              en;
    logic              rdy;
    logic              rd;
    logic              v;
    logic [DWIDTH-1:0] d;
    logic              l;
    logic [CNTW-1:0]   pkt;
    logic              bsy;
  } vec_t;

  logic [DWIDTH-1:0] fq[$];
  pend_t             pending[$];
  int now, ndel, nrd;
  int checks, failures;

  logic              s_rd, s_v, s_l, s_busy;
  logic [DWIDTH-1:0] s_d;
  logic [CNTW-1:0]   s_pkt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, now);
    end
  endtask

  task automatic push(input logic [DWIDTH-1:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle: sample at negedge, compare with the reference model,
  // then act as the FIFO on the rising edge.
  task automatic cycle();
    logic del;
    logic exp_v;
    int   outst;
    logic [DWIDTH-1:0] w;
    del = 1'b0;
    @(negedge rd_clk);
    s_rd = fifo_rd_en; s_v = m_valid; s_d = m_data; s_l = m_last;
    s_pkt = pkt_cnt; s_busy = busy;
    if (!rstn) begin
      chk("rst_rd_en", {31'd0, s_rd}, 0);
      chk("rst_valid", {31'd0, s_v}, 0);
      chk("rst_busy", {31'd0, s_busy}, 0);
      chk("rst_pkt", {24'd0, s_pkt}, 0);
    end else begin
      exp_v = (pending.size() > 0) && (pending[0].t + 2 <= now);
      chk("m_valid", {31'd0, s_v}, {31'd0, exp_v});
      if (exp_v) begin
        chk("m_data", {16'd0, s_d}, {16'd0, pending[0].w});
        chk("m_last", {31'd0, s_l}, ((ndel % PKT_LEN) == PKT_LEN - 1) ? 1 : 0);
      end
      chk("pkt_cnt", {24'd0, s_pkt}, (ndel / PKT_LEN) % 256);
      chk("busy", {31'd0, s_busy}, (pending.size() != 0) ? 1 : 0);
      del   = exp_v && m_ready;
      outst = pending.size() - (del ? 1 : 0);
      chk("fifo_rd_en", {31'd0, s_rd}, (enable && !fifo_empty && outst < 2) ? 1 : 0);
    end
    @(posedge rd_clk);
    #1;
    fifo_data = DWIDTH'($urandom);
    if (rstn) begin
      if (del) begin
        void'(pending.pop_front());
        ndel++;
      end
      if (s_rd && fq.size() > 0) begin
        w = fq.pop_front();
        pending.push_back('{w: w, t: now});
        fifo_data = w;
        nrd++;
      end
    end
    fifo_empty = (fq.size() == 0);
    now++;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, m_valid}, 0);
    chk("async_rst_data", {16'd0, m_data}, 0);
    chk("async_rst_last", {31'd0, m_last}, 0);
    pending.delete();
    fq.delete();
    ndel = 0;
    nrd = 0;
    fifo_empty = 1'b1;
    cycle();
    cycle();
    rstn = 1'b1;
  endtask

  vec_t tbl[12];
  int cnt, nlast;
  logic [DWIDTH-1:0] last_word;

  function automatic vec_t mk(input logic rd, input logic v, input logic [DWIDTH-1:0] d,
                              input logic l, input logic [CNTW-1:0] p, input logic b);
    vec_t r;
    r.en = 1'b1; r.rdy = 1'b1; r.rd = rd; r.v = v; r.d = d; r.l = l; r.pkt = p; r.bsy = b;
    return r;
  endfunction

  initial begin
    checks = 0; failures = 0; now = 0; ndel = 0; nrd = 0;
    rstn = 1'b0; enable = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;

    // Streaming 8 words from a preloaded FIFO, cycle 0 is the first cycle after reset release.
    tbl[0]  = mk(1, 0, 16'h0000, 0, 0, 0);
    tbl[1]  = mk(1, 0, 16'h0000, 0, 0, 1);
    tbl[2]  = mk(1, 1, 16'h0001, 0, 0, 1);
    tbl[3]  = mk(1, 1, 16'h0002, 0, 0, 1);
    tbl[4]  = mk(1, 1, 16'h0003, 0, 0, 1);
    tbl[5]  = mk(1, 1, 16'h0004, 1, 0, 1);
    tbl[6]  = mk(1, 1, 16'h0005, 0, 1, 1);
    tbl[7]  = mk(1, 1, 16'h0006, 0, 1, 1);
    tbl[8]  = mk(0, 1, 16'h0007, 0, 1, 1);
    tbl[9]  = mk(0, 1, 16'h0008, 1, 1, 1);
    tbl[10] = mk(0, 0, 16'h0000, 0, 2, 0);
    tbl[11] = mk(0, 0, 16'h0000, 0, 2, 0);

    do_reset();
    for (int i = 1; i <= 8; i++) push(DWIDTH'(i));
    for (int i = 0; i < 12; i++) begin
      enable = tbl[i].en;
      m_ready = tbl[i].rdy;
      cycle();
      chk("t1_rd_en", {31'd0, s_rd}, {31'd0, tbl[i].rd});
      chk("t1_valid", {31'd0, s_v}, {31'd0, tbl[i].v});
      if (tbl[i].v) chk("t1_data", {16'd0, s_d}, {16'd0, tbl[i].d});
      chk("t1_last", {31'd0, s_l}, {31'd0, tbl[i].l});
      chk("t1_pkt", {24'd0, s_pkt}, {24'd0, tbl[i].pkt});
      chk("t1_busy", {31'd0, s_busy}, {31'd0, tbl[i].bsy});
    end

    // Downstream stalled for 10 cycles: only two pops, head word held.
    do_reset();
    for (int i = 1; i <= 8; i++) push(DWIDTH'(i));
    enable = 1'b1; m_ready = 1'b0; cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_rd) cnt++;
    end
    chk("t2_stall_pops", cnt, 2);
    chk("t2_stall_data", {16'd0, s_d}, 32'h0001);
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    chk("t2_delivered", ndel, 8);

    // Alternating ready with a continuously non-empty FIFO.
    do_reset();
    for (int i = 0; i < 24; i++) push(DWIDTH'(16'h0300 + i));
    enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      m_ready = (i % 2 == 0);
      cycle();
      chk("t3_outstanding", (nrd - ndel <= 2) ? 1 : 0, 1);
    end
    chk("t3_progress", (ndel >= 10) ? 1 : 0, 1);

    // Enable dropped after the first pop: only that word comes out.
    do_reset();
    for (int i = 0; i < 6; i++) push(DWIDTH'(16'h0400 + i));
    enable = 1'b1; m_ready = 1'b1;
    cycle();
    enable = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    chk("t4_pops", nrd, 1);
    chk("t4_delivered", ndel, 1);
    chk("t4_busy", {31'd0, s_busy}, 0);
    chk("t4_fifo_left", fq.size(), 5);

    // FIFO runs dry after two words of a packet, then refills.
    do_reset();
    push(16'h00A1); push(16'h00A2);
    enable = 1'b1; m_ready = 1'b1; nlast = 0; last_word = '0;
    for (int i = 0; i < 13; i++) begin
      if (i == 7) begin push(16'h00A3); push(16'h00A4); end
      cycle();
      if (s_v && s_l) begin nlast++; last_word = s_d; end
    end
    chk("t5_last_count", nlast, 1);
    chk("t5_last_word", {16'd0, last_word}, 32'h00A4);
    chk("t5_pkt_cnt", {24'd0, s_pkt}, 1);

    // Reset pulse while streaming: outputs clear at once, framing restarts.
    do_reset();
    for (int i = 0; i < 10; i++) push(DWIDTH'(16'h0600 + i));
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    rstn = 1'b0;
    #1;
    chk("t6_rd_en", {31'd0, fifo_rd_en}, 0);
    chk("t6_valid", {31'd0, m_valid}, 0);
    chk("t6_data", {16'd0, m_data}, 0);
    chk("t6_last", {31'd0, m_last}, 0);
    chk("t6_pkt", {24'd0, pkt_cnt}, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    pending.delete(); ndel = 0; nrd = 0;
    cycle(); cycle();
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    chk("t6_delivered", ndel, 6);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      enable  = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 9) < 7);
      if (fq.size() < 16 && $urandom_range(0, 1) == 1) push(DWIDTH'($urandom));
      cycle();
    end
    enable = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    chk("rand_drain_busy", {31'd0, s_busy}, 0);
    chk("rand_all_delivered", ndel, nrd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
